// File: rtl/prog_tick_div.sv
// prog_tick_div: programmable tick/square-wave generator with safe divisor reload; ONESHOT_MODE_EN adds a halt-after-one-tick mode.
module prog_tick_div #(
  parameter int CNT_W = 40,
  parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(250000),
  parameter int TCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [CNT_W-1:0]  div_in,
  input  logic              div_load,
`ifdef ONESHOT_MODE_EN
  input  logic              oneshot,
`endif
  output logic              tick,
  output logic              cout,
  output logic [TCNT_W-1:0] tick_cnt,
  output logic              div_pend,
  output logic              running
);
  logic [CNT_W-1:0] cnt, div_q, pending;
  logic run, term, running_d;
  always_comb term = run && (cnt >= div_q);
`ifdef ONESHOT_MODE_EN
  logic halt;
  always_ff @(posedge clk)
    if (rst || clear) halt <= 1'b0;
    else if (term && oneshot) halt <= 1'b1;
  always_comb run = en & ~halt;
  always_comb running_d = run & ~(term & oneshot);
`else
  always_comb run = en;
  always_comb running_d = run;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      div_q    <= DIV_DEFAULT;
      pending  <= '0;
      div_pend <= 1'b0;
      tick     <= 1'b0;
      cout     <= 1'b0;
      tick_cnt <= '0;
      running  <= 1'b0;
    end else if (clear) begin
      cnt      <= '0;
      tick     <= 1'b0;
      cout     <= 1'b0;
      tick_cnt <= '0;
      running  <= en;
      // terminal is suppressed, so a load waits for the boundary when counting, applies now when paused
      if (div_load && en) begin
        pending  <= div_in;
        div_pend <= 1'b1;
      end else if (div_load) begin
        div_q    <= div_in;
        div_pend <= 1'b0;
      end
    end else if (term) begin
      cnt      <= '0;
      tick     <= 1'b1;
      cout     <= ~cout;
      tick_cnt <= tick_cnt + 1'b1;
      div_q    <= div_load ? div_in : div_pend ? pending : div_q;
      div_pend <= 1'b0;
      running  <= running_d;
    end else if (run) begin
      cnt     <= cnt + 1'b1;
      tick    <= 1'b0;
      running <= 1'b1;
      if (div_load) begin
        pending  <= div_in;
        div_pend <= 1'b1;
      end
    end else begin
      tick    <= 1'b0;
      running <= 1'b0;
      // paused: nothing to finish, so apply the new divisor and restart the period
      if (div_load || div_pend) begin
        div_q    <= div_load ? div_in : pending;
        cnt      <= '0;
        div_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prog_tick_div.sv
// tb_prog_tick_div: table-driven scoreboard bench; dut1 uses DIV_DEFAULT=4, dut2 uses TCNT_W=4, DIV_DEFAULT=0.
module tb_prog_tick_div;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, clear, div_load, oneshot;
  logic [39:0] div_in;
  logic tick1, cout1, pend1, run1, tick2, cout2, pend2, run2;
  logic [15:0] tcnt1;
  logic [3:0] tcnt2;
  prog_tick_div #(.CNT_W(40), .DIV_DEFAULT(40'd4), .TCNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .div_in(div_in), .div_load(div_load),
`ifdef ONESHOT_MODE_EN
    .oneshot(oneshot),
`endif
    .tick(tick1), .cout(cout1), .tick_cnt(tcnt1), .div_pend(pend1), .running(run1));
  prog_tick_div #(.CNT_W(40), .DIV_DEFAULT(40'd0), .TCNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .div_in(div_in), .div_load(div_load),
`ifdef ONESHOT_MODE_EN
    .oneshot(oneshot),
`endif
    .tick(tick2), .cout(cout2), .tick_cnt(tcnt2), .div_pend(pend2), .running(run2));
  typedef struct packed {
    logic tick, cout;
    logic [15:0] tcnt;
    logic pend, run;
  } exp_t;
  typedef struct packed {
    logic rst, en, clr, ld, os;
    logic [7:0] din;
    exp_t e;
  } vec_t;
  vec_t v[$];
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  task automatic add(input logic r, input logic e_n, input logic c, input logic l, input logic o,
                     input logic [7:0] d, input logic t, input logic co, input logic [15:0] tc,
                     input logic p, input logic ru);
    vec_t x;
    x.rst = r; x.en = e_n; x.clr = c; x.ld = l; x.os = o; x.din = d;
    x.e = '{tick: t, cout: co, tcnt: tc, pend: p, run: ru};
    v.push_back(x);
  endtask
  task automatic apply(input vec_t x, input int s, input int idx);
    exp_t e, g;
    @(negedge clk);
    rst = x.rst; en = x.en; clear = x.clr; div_load = x.ld; oneshot = x.os; div_in = {32'b0, x.din};
    sb.push_back(x.e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    g = s != 0 ? '{tick: tick2, cout: cout2, tcnt: {12'b0, tcnt2}, pend: pend2, run: run2}
               : '{tick: tick1, cout: cout1, tcnt: tcnt1, pend: pend1, run: run1};
    n_chk++;
    if (g == e) n_pass++;
    else $display("FAIL dut%0d step %0d: got tick=%b cout=%b tcnt=%0d pend=%b run=%b, want tick=%b cout=%b tcnt=%0d pend=%b run=%b",
                  s + 1, idx, g.tick, g.cout, g.tcnt, g.pend, g.run, e.tick, e.cout, e.tcnt, e.pend, e.run);
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; div_load = 1'b0; oneshot = 1'b0; div_in = '0;
    add(1,0,0,0,0,0, 0,0,0,0,0);
    for (int k = 1; k <= 15; k++)
      add(0,1,0,0,0,0, (k % 5) == 0, ((k / 5) % 2) == 1, 16'(k / 5), 0, 1);
    add(0,1,0,0,0,0, 0,1,3,0,1);
    add(0,1,0,1,0,2, 0,1,3,1,1);
    add(0,1,0,0,0,0, 0,1,3,1,1);
    add(0,1,0,0,0,0, 0,1,3,1,1);
    add(0,1,0,0,0,0, 1,0,4,0,1);
    add(0,1,0,0,0,0, 0,0,4,0,1);
    add(0,1,0,0,0,0, 0,0,4,0,1);
    add(0,1,0,0,0,0, 1,1,5,0,1);
    add(0,1,0,0,0,0, 0,1,5,0,1);
    add(0,1,0,0,0,0, 0,1,5,0,1);
    add(0,1,0,0,0,0, 1,0,6,0,1);
    add(0,1,0,0,0,0, 0,0,6,0,1);
    add(0,1,0,0,0,0, 0,0,6,0,1);
    add(0,1,0,1,0,5, 1,1,7,0,1);
    add(0,1,0,0,0,0, 0,1,7,0,1);
    add(0,1,0,0,0,0, 0,1,7,0,1);
    add(0,1,0,0,0,0, 0,1,7,0,1);
    add(0,0,0,1,0,1, 0,1,7,0,0);
    add(0,1,0,0,0,0, 0,1,7,0,1);
    add(0,1,0,0,0,0, 1,0,8,0,1);
    add(0,1,0,0,0,0, 0,0,8,0,1);
    add(0,1,0,0,0,0, 1,1,9,0,1);
    add(0,1,0,0,0,0, 0,1,9,0,1);
    add(0,1,1,0,0,0, 0,0,0,0,1);
    add(0,1,0,0,0,0, 0,0,0,0,1);
    add(0,1,0,0,0,0, 1,1,1,0,1);
    add(0,1,0,1,0,3, 0,1,1,1,1);
    add(0,0,0,0,0,0, 0,1,1,0,0);
    for (int k = 0; k < 3; k++) add(0,1,0,0,0,0, 0,1,1,0,1);
    add(0,1,0,0,0,0, 1,0,2,0,1);
    add(0,1,0,1,0,7, 0,0,2,1,1);
    add(0,1,0,1,0,1, 0,0,2,1,1);
    add(0,1,0,0,0,0, 0,0,2,1,1);
    add(0,1,0,0,0,0, 1,1,3,0,1);
    add(0,1,0,0,0,0, 0,1,3,0,1);
    add(0,1,0,0,0,0, 1,0,4,0,1);
    add(0,1,0,1,0,9, 0,0,4,1,1);
    add(1,1,0,0,0,0, 0,0,0,0,0);
    for (int k = 0; k < 4; k++) add(0,1,0,0,0,0, 0,0,0,0,1);
    add(0,1,0,0,0,0, 1,1,1,0,1);
    add(0,1,1,1,0,2, 0,0,0,1,1);
    for (int k = 0; k < 4; k++) add(0,1,0,0,0,0, 0,0,0,1,1);
    add(0,1,0,0,0,0, 1,1,1,0,1);
    add(0,0,0,0,0,0, 0,1,1,0,0);
    add(0,0,0,0,0,0, 0,1,1,0,0);
    add(0,1,0,0,0,0, 0,1,1,0,1);
    add(0,1,0,0,0,0, 0,1,1,0,1);
    add(0,1,0,0,0,0, 1,0,2,0,1);
`ifdef ONESHOT_MODE_EN
    add(1,0,0,0,0,0, 0,0,0,0,0);
    for (int k = 0; k < 4; k++) add(0,1,0,0,1,0, 0,0,0,0,1);
    add(0,1,0,0,1,0, 1,1,1,0,0);
    add(0,1,0,0,1,0, 0,1,1,0,0);
    add(0,1,0,0,1,0, 0,1,1,0,0);
    add(0,1,1,0,0,0, 0,0,0,0,1);
    add(0,1,0,0,0,0, 0,0,0,0,1);
`endif
    foreach (v[i]) apply(v[i], 0, i);
    // dut2: divisor 0 keeps tick high and wraps the 4-bit tick counter
    v.delete();
    add(1,0,0,0,0,0, 0,0,0,0,0);
    for (int k = 1; k <= 17; k++)
      add(0,1,0,0,0,0, 1, (k % 2) == 1, 16'(k % 16), 0, 1);
    foreach (v[i]) apply(v[i], 1, i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/prog_tick_div.md
Name: prog_tick_div

Overview:
- Parametrised, runtime-programmable clock-enable/tick generator that derives game timing (beat ticks, sub-second timers) from the 50 MHz system clock.
- Produces a one-cycle tick pulse and a 50%-duty square output.
- Supports glitch-free divisor reload at period boundaries, pause/clear, and an elapsed-tick counter.
- Sits between the system clock and the game/score/display timing logic. It replaces fixed-ratio dividers.

Parameters:
- CNT_W, 40, width of the period counter and divisor.
- DIV_DEFAULT, 250000, divisor after reset; tick period = div+1 cycles.
- TCNT_W, 16, width of the elapsed-tick counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; 0 = pause (state held).
- clear  in  1  strobe; restart period and zero phase/tick count.
- div_in  in  CNT_W  new divisor value.
- div_load  in  1  strobe; request divisor update from div_in.
- tick  out  1  one-cycle pulse per period (registered).
- cout  out  1  square wave; toggles once per period.
- tick_cnt  out  TCNT_W  ticks since reset/clear; wraps.
- div_pend  out  1  a loaded divisor is waiting for the period boundary.
- running  out  1  block is actively counting.

Behaviour:
- Reset values: cnt=0, div_q=DIV_DEFAULT, tick=0, cout=0, tick_cnt=0, div_pend=0, pending reg=0, running=0 during the reset cycle.
- Reset has priority over every other input.
- Priority after rst: clear > terminal count / div_load > plain count.
- Terminal condition: en=1 and cnt >= div_q. Using ">=" makes a divisor shrink safe.
- On the terminal edge:
  - cnt<=0, tick<=1, cout<=~cout, tick_cnt<=tick_cnt+1 (mod 2^TCNT_W).
  - If div_pend=1: div_q<=pending, div_pend<=0.
- Non-terminal edge with en=1: cnt<=cnt+1, tick<=0.
- Period:
  - tick = div_q+1 cycles; cout period = 2*(div_q+1), 50% duty.
  - div_q=0: tick held high every cycle, cout toggles every cycle.
- Latency: tick and cout change on the edge that samples cnt >= div_q. First tick after reset/clear with en=1 continuously occurs on the (div_q+1)th enabled edge.
- div_load with en=1, not on a terminal edge: pending<=div_in, div_pend<=1. The current period finishes on the old divisor.
- div_load on a terminal edge: div_q<=div_in directly (overrides any pending value), div_pend<=0. The next period uses the new value.
- div_load while div_pend=1: last write wins.
- en=0: cnt, cout and tick_cnt hold; tick<=0.
  - If div_pend=1, or div_load=1, at that edge: div_q<=new value (div_in takes precedence over pending), cnt<=0, div_pend<=0.
- clear: cnt<=0, tick<=0, cout<=0, tick_cnt<=0.
  - Terminal event in the same cycle is suppressed.
  - div_q, pending and div_pend are unaffected.
  - A div_load in the same cycle is still captured, per the rules above.
- running = en (and not halted, see the optional feature), registered from the same edge.

Optional Feature:
- Macro: ONESHOT_MODE_EN.
- Defined:
  - Adds input port oneshot (1 bit) and an internal halt flag (reset 0).
  - A terminal edge with oneshot=1 produces a normal tick/cout toggle, then sets halt.
  - While halt=1: counting stops (cnt=0, no ticks) and running=0.
  - clear or rst releases halt.
- Not defined: no oneshot port, no halt logic; running = en; free-running only.

Test Plan:
- DIV_DEFAULT=4, release rst, en=1 -> tick pulses on edges 5, 10, 15; cout=1 after edge 5 and 0 after edge 10; tick_cnt 1, 2, 3.
- DIV_DEFAULT=4, div_load with div_in=2 at cnt=1 -> div_pend=1 until the next terminal; subsequent tick period 3 cycles; div_pend=0 after.
- Shrink while paused: cnt=3, en=0, div_load div_in=1 -> next edge cnt=0, div_q=1; en=1 gives ticks every 2 cycles, no missed or extra tick.
- TCNT_W=4, DIV_DEFAULT=0, en=1 for 17 cycles -> tick held high; tick_cnt sequence wraps 15->0 and reads 1 after edge 17.
- clear asserted on a terminal cycle with cout=1 -> no tick, cout=0, tick_cnt=0, cnt=0; next tick after div_q+1 edges.
- rst asserted mid-period with div_pend=1 -> all outputs at reset values; div_q=DIV_DEFAULT. With ONESHOT_MODE_EN and oneshot=1: exactly one tick, then running=0 until clear.
